debounce_filter: RTL

- Per-bit debouncer and edge detector that sits directly downstream of the synchronization chain.
- Consumes already-synchronized button/switch lines and presents glitch-free levels plus single-cycle rise/fall strobes to control logic.
- A level change is accepted only after it has been held for STABLE_CYCLES consecutive clock edges. Shorter excursions are discarded.

---
 rtl/debounce_filter_pkg.sv | 26 ++
 rtl/debounce_filter_channel.sv | 101 ++++++++++
 rtl/debounce_filter.sv | 40 ++++
 3 files changed

// File: rtl/debounce_filter_pkg.sv
// rtl/debounce_filter_pkg.sv - shared types and helpers for the debounce filter
//
// Purpose : per-channel state encoding and a constant clog2 used to size
//           the qualification counters.
// Contents: chan_state_e (ST_STABLE = 0, ST_QUALIFY = 1), clog2().
package debounce_filter_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } chan_state_e;

    // Ceiling log2, never less than 1 so that a counter always has one bit.
    function automatic int clog2(input int value);
        int          result;
        longint      power;
        result = 0;
        power  = 1;
        while (power < longint'(value)) begin
            power  = power << 1;
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/debounce_filter_channel.sv
// rtl/debounce_filter_channel.sv - single-line debouncer with edge strobes
//
// Purpose : accepts a new level on i_input only after it has differed from
//           the current level for STABLE_CYCLES consecutive clock edges.
// Ports   : i_clk    clock, posedge
//           i_rst_n  asynchronous active-low reset
//           i_input  synchronized raw line
//           o_level  debounced level (registered)
//           o_rise   one-cycle strobe on accepted 0->1
//           o_fall   one-cycle strobe on accepted 1->0
module debounce_filter_channel
    import debounce_filter_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    parameter logic INIT_VALUE    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_input,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CW        = clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST      = CW'(STABLE_CYCLES - 1);
    // With a single required sample the first differing edge is also the last.
    localparam bit             IMMEDIATE = (STABLE_CYCLES == 1);

    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= INIT_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The counter holds the number of differing samples already seen, so
    // the first differing edge loads 1 and acceptance happens on the edge
    // where the count reaches STABLE_CYCLES-1 (the STABLE_CYCLES-th sample).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (i_input != level_q) begin
                    if (IMMEDIATE) begin
                        level_d = i_input;
                        rise_d  = i_input;
                        fall_d  = ~i_input;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = ST_QUALIFY;
                    end
                end
            end
            ST_QUALIFY: begin
                // Returning to the old level wins even on the final edge.
                if (i_input == level_q) begin
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                    level_d = i_input;
                    rise_d  = i_input;
                    fall_d  = ~i_input;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_STABLE;
            end
        endcase
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - WIDTH independent debouncers with edge strobes
//
// Purpose : debounces already-synchronized lines; each bit is an independent
//           debounce_filter_channel.
// Ports   : i_clk     clock, posedge
//           i_rst_n   asynchronous active-low reset
//           iv_input  synchronized raw lines [WIDTH]
//           ov_level  debounced levels [WIDTH]
//           ov_rise   one-cycle 0->1 strobes [WIDTH]
//           ov_fall   one-cycle 1->0 strobes [WIDTH]
module debounce_filter
    import debounce_filter_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] iv_input,
    output logic [WIDTH-1:0] ov_level,
    output logic [WIDTH-1:0] ov_rise,
    output logic [WIDTH-1:0] ov_fall
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_chan
        debounce_filter_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .INIT_VALUE    (INIT_VALUE[b])
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_input (iv_input[b]),
            .o_level (ov_level[b]),
            .o_rise  (ov_rise[b]),
            .o_fall  (ov_fall[b])
        );
    end

endmodule
